// File: rtl/rf_dump_pkg.sv
// rf_dump_pkg: shared state encoding, ASCII constants and sizing helper for the register dump engine
package rf_dump_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ADDR,
      S_COLON,
      S_DATA,
      S_NL,
      S_DONE
   } state_t;

   localparam logic [7:0] CHAR_COLON = 8'h3A;
   localparam logic [7:0] CHAR_LF    = 8'h0A;
   localparam logic [7:0] CHAR_0     = 8'h30;
   localparam logic [7:0] CHAR_A     = 8'h41;

   // Index width for n items, never below one bit so a single-nibble word still has a counter
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rf_dump_hex_ascii.sv
// hex_ascii: combinational nibble to uppercase ASCII hex digit
import rf_dump_pkg::*;

module hex_ascii (
   input  logic [3:0] nib_i,
   output logic [7:0] char_o
);

   // Digits 0-9 map onto '0'..'9', 10-15 onto 'A'..'F'
   always_comb begin
      char_o = (nib_i < 4'd10) ? CHAR_0 + 8'(nib_i) : CHAR_A + 8'(nib_i) - 8'd10;
   end

endmodule

// File: rtl/rf_dump.sv
// rf_dump: sweeps the register file monitor port and streams each register as an "AA:DDDD..\n" hex line; RF_DUMP_SKIP_ZERO_EN suppresses lines for zero registers
import rf_dump_pkg::*;

module rf_dump #(
   parameter int REG_W = 5,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [REG_W-1:0] m_rf_addr,
   input  logic [WIDTH-1:0] rf_data,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready
);

`ifdef RF_DUMP_SKIP_ZERO_EN
   localparam bit SKIP_ZERO = 1'b1;
`else
   localparam bit SKIP_ZERO = 1'b0;
`endif

   localparam int NIBS  = WIDTH / 4;
   localparam int IDX_W = idx_w(NIBS);

   state_t             state_q;
   logic [REG_W:0]     addr_q;
   logic [IDX_W-1:0]   idx_q;
   logic [WIDTH-1:0]   snap_q;
   logic [7:0]         out_data_q;
   logic               out_valid_q;
   logic               busy_q;
   logic               done_q;

   logic [REG_W:0]     addr_d;
   logic [7:0]         addr8;
   logic [WIDTH-1:0]   snap_d;
   logic [3:0]         nib;
   logic [7:0]         char_d;
   logic               last;
   logic               xfer;
   logic               skip;

   assign busy      = busy_q;
   assign done      = done_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign m_rf_addr = addr_q[REG_W-1:0];

   // Pick the nibble of the byte that will be presented after the current one; the snapshot is consumed MSB-first by shifting
   always_comb begin
      addr_d = addr_q + 1'b1;
      addr8  = 8'(addr_q[REG_W-1:0]);
      snap_d = snap_q << 4;
      last   = addr_d[REG_W];
      xfer   = out_valid_q & out_ready;
      skip   = SKIP_ZERO && (rf_data == '0);
      nib    = (state_q == S_FETCH) ? addr8[7:4] :
               (state_q == S_ADDR)  ? addr8[3:0] :
               (state_q == S_COLON) ? snap_q[WIDTH-1 -: 4] :
                                      snap_d[WIDTH-1 -: 4];
   end

   hex_ascii u_hex (
      .nib_i  (nib),
      .char_o (char_d)
   );

   // Dump sequencer: each output byte is loaded on the edge that accepts the previous one
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         idx_q       <= '0;
         snap_q      <= '0;
         out_data_q  <= 8'h00;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_FETCH;
                  addr_q  <= '0;
                  busy_q  <= 1'b1;
               end
            end
            S_FETCH: begin
               snap_q <= rf_data;
               if (!skip) begin
                  state_q     <= S_ADDR;
                  idx_q       <= '0;
                  out_data_q  <= char_d;
                  out_valid_q <= 1'b1;
               end else if (last) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  addr_q <= addr_d;
               end
            end
            S_ADDR: begin
               if (xfer) begin
                  if (idx_q == '0) begin
                     idx_q      <= idx_q + 1'b1;
                     out_data_q <= char_d;
                  end else begin
                     state_q    <= S_COLON;
                     out_data_q <= CHAR_COLON;
                  end
               end
            end
            S_COLON: begin
               if (xfer) begin
                  state_q    <= S_DATA;
                  idx_q      <= '0;
                  out_data_q <= char_d;
               end
            end
            S_DATA: begin
               if (xfer) begin
                  if (idx_q == IDX_W'(NIBS - 1)) begin
                     state_q    <= S_NL;
                     out_data_q <= CHAR_LF;
                  end else begin
                     idx_q      <= idx_q + 1'b1;
                     snap_q     <= snap_d;
                     out_data_q <= char_d;
                  end
               end
            end
            S_NL: begin
               if (xfer) begin
                  out_valid_q <= 1'b0;
                  if (last) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_FETCH;
                     addr_q  <= addr_d;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               addr_q  <= '0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rf_dump.sv
// tb_rf_dump: randomized and directed self-checking bench for rf_dump against a text-level model of the dump stream
module tb_rf_dump;

`ifdef RF_DUMP_SKIP_ZERO_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        busy;
   logic        done;
   logic [4:0]  m_rf_addr;
   logic [31:0] rf_data;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;

   logic [31:0] regs [32];
   logic [7:0]  got [$];
   logic [7:0]  exp_q [$];
   int          exp_cyc;
   int          checks = 0;
   int          errors = 0;
   int          done_cnt = 0;
   int          stall_n = 0;
   int          stall_bad = 0;
   bit          bp = 1'b0;
   bit          prev_stall = 1'b0;
   logic [7:0]  prev_data = 8'h00;

   assign rf_data = regs[m_rf_addr];

   rf_dump dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .m_rf_addr (m_rf_addr),
      .rf_data   (rf_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         out_ready = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               stall_n++;
               if (!(out_valid === 1'b1 && out_data === prev_data)) stall_bad++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (out_valid && out_ready) got.push_back(out_data);
            if (done) done_cnt++;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected stream: one printf-formatted line per register, and one cycle for the fetch plus one per byte at full rate
   function automatic void model();
      string s;
      exp_q.delete();
      exp_cyc = 0;
      for (int n = 0; n < 32; n++) begin
         exp_cyc++;
         if (SKIP && regs[n] == 32'h0) continue;
         s = $sformatf("%02h:%08h\n", 8'(n), regs[n]);
         s = s.toupper();
         for (int i = 0; i < s.len(); i++) begin
            exp_q.push_back(s[i]);
            exp_cyc++;
         end
      end
   endfunction

   task automatic check_stream(input string tag);
      int bad;
      bad = -1;
      check({tag, "_len"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         if (got[i] !== exp_q[i]) begin
            bad = i;
            break;
         end
      end
      check({tag, "_first_bad_byte"}, bad, -1);
   endtask

   task automatic clear_regs();
      for (int n = 0; n < 32; n++) regs[n] = 32'h0;
   endtask

   task automatic run_dump(input string tag, input int pulse_at, input int poke_at,
                           input int poke_a, input logic [31:0] poke_v, input bit timed);
      int cyc;
      cyc = -1;
      got.delete();
      done_cnt = 0;
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check({tag, "_fetch0_busy"}, busy, 1'b1);
      check({tag, "_fetch0_addr"}, m_rf_addr, 5'd0);
      for (int k = 1; k <= 20000; k++) begin
         @(negedge clk);
         start = (k == pulse_at);
         if (k == poke_at) regs[poke_a] = poke_v;
         if (done) begin
            cyc = k;
            break;
         end
      end
      start = 1'b0;
      check({tag, "_busy_at_done"}, busy, 1'b0);
      if (timed) check({tag, "_done_cycle"}, cyc, exp_cyc);
      else check({tag, "_done_seen"}, cyc > 0, 1'b1);
      check_stream(tag);
      repeat (20) @(negedge clk);
      check({tag, "_done_pulses"}, done_cnt, 1);
      check({tag, "_idle_busy"}, busy, 1'b0);
      check({tag, "_idle_addr"}, m_rf_addr, 5'd0);
   endtask

   initial begin
      clear_regs();
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_valid", out_valid, 1'b0);
      check("rst_data", out_data, 8'h00);
      check("rst_addr", m_rf_addr, 5'd0);

      regs[5]  = 32'h12345678;
      regs[31] = 32'hDEADBEEF;
      model();
      run_dump("lines", 0, 0, 0, 32'h0, 1'b1);

      bp = 1'b1;
      stall_n = 0;
      stall_bad = 0;
      run_dump("backpressure", 0, 0, 0, 32'h0, 1'b0);
      check("bp_stalls_seen", stall_n > 0, 1'b1);
      check("bp_stall_stable", stall_bad, 0);
      bp = 1'b0;
      repeat (2) @(posedge clk);

      regs[7] = 32'hAAAAAAAA;
      model();
      run_dump("snapshot", 0, 93, 7, 32'h55555555, 1'b1);
      regs[7] = 32'h0;

      model();
      run_dump("start_busy", 200, 0, 0, 32'h0, 1'b1);

      done_cnt = 0;
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (50) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_valid", out_valid, 1'b0);
      check("abort_data", out_data, 8'h00);
      check("abort_addr", m_rf_addr, 5'd0);
      repeat (20) @(negedge clk);
      check("abort_no_done", done_cnt, 0);
      run_dump("restart", 0, 0, 0, 32'h0, 1'b1);

      clear_regs();
      model();
      run_dump("all_zero", 0, 0, 0, 32'h0, 1'b1);

      for (int r = 0; r < 2; r++) begin
         for (int n = 0; n < 32; n++) regs[n] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
         model();
         bp = (r == 1);
         run_dump(r == 0 ? "random_full" : "random_bp", 0, 0, 0, 32'h0, r == 0);
         bp = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rf_dump.md
# rf_dump

Debug read-out engine on the far side of the register file's monitor port (`m_rf_addr`/`rf_data`). On a start pulse it sweeps every register address, samples each word, and emits it as uppercase ASCII hex text, one line per register, on a byte stream with valid/ready handshake. The stream feeds the board UART transmitter or an on-screen console. It lets the team inspect architectural state without halting the datapath.

## Interface
- `REG_W`, default 5: register address width. Must be 1..8. The register file has 2^REG_W entries.
- `WIDTH`, default 32: register data width. Must be a multiple of 4.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: single-cycle request to begin a dump. Sampled only in IDLE.
- `busy`, out, 1: high from the cycle after start is accepted until `done`.
- `done`, out, 1: one-cycle pulse when the dump completes.
- `m_rf_addr`, out, REG_W: monitor read address sent to the register file.
- `rf_data`, in, WIDTH: monitor read data. Combinational in `m_rf_addr`.
- `out_data`, out, 8: ASCII byte.
- `out_valid`, out, 1: byte available.
- `out_ready`, in, 1: sink accepts the byte. A transfer occurs when `out_valid` and `out_ready` are both high.

## Operation
- Line format for register n: 2 address hex chars (n zero-extended to 8 bits), then `:` (0x3A), then WIDTH/4 data hex chars (MSB nibble first), then LF (0x0A).
  - Example: `05:12345678\n`, which is 12 bytes at WIDTH=32.
- Hex digits: values 0–9 map to 0x30–0x39; values 10–15 map to 0x41–0x46.
- States: IDLE → FETCH → ADDR (2 chars) → COLON → DATA (WIDTH/4 chars) → NL.
  - After NL, go to FETCH for the next address, or to DONE after address 2^REG_W−1.
  - DONE → IDLE.
- FETCH:
  - `m_rf_addr` holds the current address.
  - `rf_data` is captured into an internal snapshot at the end of the cycle.
  - The line is printed from the snapshot, so later register writes do not alter a line in progress.
- ADDR, COLON, DATA and NL each present one byte. The state and char index advance only on a transfer.
- `out_data` and `out_valid` are registered outputs. They stay stable while `out_valid=1` and `out_ready=0`.
- `start` is ignored while `busy`.
- Counters:
  - Address counter is REG_W+1 bits, so the terminal compare has no wrap-around aliasing.
  - Nibble index is ceil(log2(WIDTH/4)) bits.
- `m_rf_addr` holds its last value outside FETCH. It is 0 in IDLE.

## Timing
- Reset values:
  - `busy=0`, `done=0`, `out_valid=0`, `out_data=0x00`, `m_rf_addr=0`.
  - State = IDLE, snapshot = 0.
- Reset mid-dump aborts immediately. The next cycle shows the reset values, and no `done` pulse is produced.
- Start sequence:
  - `start` accepted in cycle N (IDLE).
  - Cycle N+1: FETCH with `m_rf_addr=0`, `busy=1`.
  - Cycle N+2: first byte valid.
- With `out_ready` held at 1:
  - Each byte takes 1 cycle.
  - Each register takes 1 + 4 + WIDTH/4 cycles: 13 at the defaults.
  - A full dump takes 416 cycles from FETCH of register 0 to acceptance of the last LF.
- `done` pulses in the cycle after the final LF transfer. `busy` drops in that same cycle.
- `start` arriving together with `done` is ignored. A new start is accepted one cycle later, in IDLE.

## Configuration
- Macro: `RF_DUMP_SKIP_ZERO_EN`.
- Defined:
  - A register whose snapshot equals 0 emits no line.
  - FETCH goes directly to the next FETCH, or to DONE if the register was the last.
  - Each skipped register costs 1 cycle.
  - Register 0 is always skipped, because it reads 0.
  - If every register is 0, no bytes are emitted and `done` pulses 2^REG_W cycles after the first FETCH.
- Undefined: every register is printed, zero values included.

## Structure
- Package `rf_dump_pkg` holds:
  - the state enum;
  - ASCII constants: `CHAR_COLON`=0x3A, `CHAR_LF`=0x0A, `CHAR_0`=0x30, `CHAR_A`=0x41.
- Sub-module `hex_ascii`: combinational 4-bit nibble to 8-bit ASCII. It is shared by the ADDR and DATA states.

## Test plan
- Reset:
  - Hold `rst=0` for 3 cycles during an active dump → all outputs are at reset values and there is no `done` pulse.
  - After release, start → the dump restarts at register 0.
- Single-line check:
  - Preload reg5=0x12345678 and reg31=0xDEADBEEF, others 0, with `out_ready=1` and the macro off.
  - Expected lines: `05:12345678\n` and `1F:DEADBEEF\n`.
  - 384 bytes in total; `done` at FETCH0+416.
- Backpressure:
  - Drive `out_ready` with a pseudo-random 30% duty cycle → `out_data` is stable whenever it is stalled.
  - The byte stream is identical to the unstalled run.
- Snapshot:
  - Write reg7 from 0xAAAAAAAA to 0x55555555 two cycles after reg7's FETCH.
  - Expected line: `07:AAAAAAAA\n`.
- Start while busy: pulse `start` mid-dump → no restart, and exactly one `done` pulse.
- `RF_DUMP_SKIP_ZERO_EN` defined:
  - Only reg5 is non-zero → stream is exactly `05:12345678\n`.
  - All registers zero → 0 bytes, and `done` at FETCH0+32.
